// File: rtl/foo_write_arbiter_if.sv
// Requester-side handshake bundle and shared foo register outputs of the write arbiter.
interface foo_write_arbiter_if #(
  parameter int N = 5,
  parameter int W = 8
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_lock;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   foo;
  logic           foo_we;
  logic [IDW-1:0] grant_id;
  logic           busy;

  modport master (
    output req_valid, req_lock, req_data,
    input  req_ready, foo, foo_we, grant_id, busy
  );

  modport slave (
    input  req_valid, req_lock, req_data,
    output req_ready, foo, foo_we, grant_id, busy
  );
endinterface

// File: rtl/foo_write_arbiter.sv
// Round-robin arbiter sharing the foo register among N requesters, with
// optional burst locking of the grant for up to MAX_BURST beats.
module foo_write_arbiter #(
  parameter int N         = 5,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  foo_write_arbiter_if.slave    bus
);
  // state     | meaning
  // ST_IDLE   | round-robin scan from r_ptr, any valid requester may win
  // ST_LOCKED | grant held by r_owner until release, unlocked beat or burst limit
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t         r_state;
  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  r_owner;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_foo;
  logic           r_foo_we;
  logic [PW-1:0]  r_grant_id;

  logic           w_found;
  logic [PW-1:0]  w_winner;
  logic [PW:0]    w_idx;
  logic [N-1:0]   w_ready;
  logic           w_accept;
  logic [PW-1:0]  w_sel;
  logic [W-1:0]   w_sel_data;
  logic [CW-1:0]  w_cnt_inc;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] x);
    return (x == PW'(N - 1)) ? '0 : x + 1'b1;
  endfunction

  // First valid requester at or after r_ptr, wrapping modulo N.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(N)) w_idx = w_idx - (PW+1)'(N);
      if (!w_found && bus.req_valid[w_idx[PW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_ready    = '0;
    w_sel      = (r_state == ST_LOCKED) ? r_owner : w_winner;
    w_sel_data = '0;
    if (i_rst_n && i_en) begin
      if (r_state == ST_LOCKED) w_ready[r_owner] = bus.req_valid[r_owner];
      else if (w_found)         w_ready[w_winner] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (w_sel == PW'(i)) w_sel_data = bus.req_data[i*W +: W];
    end
    w_accept  = |w_ready;
    w_cnt_inc = r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_cnt      <= '0;
      r_foo      <= '0;
      r_foo_we   <= 1'b0;
      r_grant_id <= '0;
    end else begin
      r_foo_we <= 1'b0;
      if (w_accept) begin
        r_foo      <= w_sel_data;
        r_foo_we   <= 1'b1;
        r_grant_id <= w_sel;
      end
      if (i_en) begin
        if (r_state == ST_IDLE) begin
          if (w_accept) begin
            if (bus.req_lock[w_winner] && (MAX_BURST > 1)) begin
              r_state <= ST_LOCKED;
              r_owner <= w_winner;
              r_cnt   <= CW'(1);
            end else begin
              r_ptr <= f_inc(w_winner);
            end
          end
        end else begin
          // Without an accepted beat while enabled, the owner dropped valid: release.
          if (!w_accept || !bus.req_lock[r_owner] || (w_cnt_inc == CW'(MAX_BURST))) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= f_inc(r_owner);
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.foo       = r_foo;
  assign bus.foo_we    = r_foo_we;
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = (r_state == ST_LOCKED);

endmodule
